// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the two-port RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int WORD_W = 32
);
    logic [1:0]        req_ren;
    logic [1:0]        req_wen;
    logic [WORD_W-1:0] req_addr0;
    logic [WORD_W-1:0] req_addr1;
    logic [WORD_W-1:0] req_store0;
    logic [WORD_W-1:0] req_store1;
    logic [WORD_W-1:0] req_load;
    logic [1:0]        req_wait;
    logic [1:0]        req_err;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  req_ren, req_wen, req_addr0, req_addr1,
        input  req_store0, req_store1, ramload, ramstate,
        output req_load, req_wait, req_err,
        output ramaddr, ramstore, ramREN, ramWEN
    );

    modport master (
        output req_ren, req_wen, req_addr0, req_addr1,
        output req_store0, req_store1, ramload, ramstate,
        input  req_load, req_wait, req_err,
        input  ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters.
// Define RAM_TIMEOUT_EN to build in the 8-bit ownership watchdog.
module ram_port_arbiter #(
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               CLK,
    input logic               RST,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, OWNED} state_e;
    localparam logic [1:0] ACCESS = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        active;
    logic              own_act, own_ren, own_wen, done;
    logic [WORD_W-1:0] own_addr, own_store;
    logic              expire;
    logic [1:0]        err;

    assign active    = bus.req_ren | bus.req_wen;
    assign own_ren   = owner_q ? bus.req_ren[1] : bus.req_ren[0];
    assign own_wen   = owner_q ? bus.req_wen[1] : bus.req_wen[0];
    assign own_act   = own_ren | own_wen;
    assign own_addr  = owner_q ? bus.req_addr1 : bus.req_addr0;
    assign own_store = owner_q ? bus.req_store1 : bus.req_store0;
    assign done      = bus.ramstate == ACCESS;

`ifdef RAM_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wdog_q, wdog_d;

    // Fires in the OWNED cycle that brings the count to TIMEOUT_CYCLES.
    assign expire = (state_q == OWNED) && own_act && !done
                    && (wdog_q == LIMIT);
    assign err    = expire ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        wdog_d = 8'd0;
        if (state_q == OWNED) wdog_d = wdog_q + 8'd1;
    end
`else
    assign expire = 1'b0;
    assign err    = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = OWNED;
                    owner_d = (&active) ? ptr_q : active[1];
                end
            end
            OWNED: begin
                // An abandoned request leaves the pointer where it was.
                if (!own_act) begin
                    state_d = IDLE;
                end else if (done || expire) begin
                    state_d = IDLE;
                    ptr_d   = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.req_wait = 2'b00;
        bus.req_err  = 2'b00;
        if (!RST) begin
            bus.req_err = err;
            if (state_q == IDLE) begin
                bus.req_wait = active;
            end else begin
                bus.ramaddr            = own_addr;
                bus.ramstore           = own_store;
                bus.ramWEN             = own_wen;
                bus.ramREN             = own_ren & ~own_wen;
                bus.req_wait[owner_q]  = !done;
                bus.req_wait[~owner_q] = active[~owner_q];
            end
        end
    end

    assign bus.req_load = bus.ramload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
`ifdef RAM_TIMEOUT_EN
            wdog_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef RAM_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles; legal range 1..255.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_ren  input  2  per-requester read request; bit i belongs to requester i.
REQ-006 SHALL have port req_wen  input  2  per-requester write request.
REQ-007 SHALL have ports req_addr0 and req_addr1  input  WORD_W  per-requester address.
REQ-008 SHALL have ports req_store0 and req_store1  input  WORD_W  per-requester write data.
REQ-009 SHALL have port req_load  output  WORD_W  read data, shared by both requesters.
REQ-010 SHALL have port req_wait  output  2  per-requester stall; low means the access completes this cycle.
REQ-011 SHALL have port req_err  output  2  per-requester one-cycle timeout abort pulse.
REQ-012 SHALL have ports ramaddr and ramstore  output  WORD_W  RAM address and write data.
REQ-013 SHALL have ports ramREN and ramWEN  output  1  RAM read and write strobes.
REQ-014 SHALL have port ramload  input  WORD_W  RAM read data.
REQ-015 SHALL have port ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-016 SHALL implement a registered FSM with two states, IDLE and OWNED, plus a 1-bit owner register and a 1-bit round-robin priority pointer.
REQ-017 A requester is active when its req_ren or req_wen bit is high.
REQ-018 In IDLE, with at least one active requester: next state is OWNED; owner is the sole active requester, or the requester named by the pointer when both are active.
REQ-019 In IDLE, all RAM strobes SHALL be 0, ramaddr and ramstore SHALL be 0, and req_wait SHALL equal the active bits; this costs one arbitration cycle.
REQ-020 In OWNED, ramaddr, ramstore, ramREN and ramWEN SHALL combinationally follow the owner's inputs.
REQ-021 If the owner has both req_wen and req_ren high, only ramWEN SHALL assert.
REQ-022 In OWNED, the non-owner's req_wait SHALL be 1 whenever that requester is active.
REQ-023 In OWNED, the owner's req_wait SHALL be 0 exactly in cycles where ramstate==ACCESS, and 1 otherwise; ramstate BUSY, FREE and ERROR all keep it stalled.
REQ-024 req_load SHALL equal ramload in every cycle.
REQ-025 On OWNED with ramstate==ACCESS: next state is IDLE and the pointer is set to the non-owner.
REQ-026 If the owner deasserts both strobes while in OWNED, next state is IDLE, the transaction is abandoned and the pointer is unchanged.
REQ-027 A request asserted in the same cycle that the other requester completes SHALL be granted on the following IDLE cycle.
REQ-028 Under continuous requests from both requesters, grants SHALL alternate strictly 0,1,0,1...
REQ-029 Neither requester SHALL wait more than one complete foreign transaction plus two cycles before being granted.

Reset
REQ-030 While RST is high: state=IDLE, owner=0, pointer=0, watchdog=0.
REQ-031 All outputs SHALL be 0 while RST is high, except req_load, which follows ramload.
REQ-032 RST asserted mid-transaction SHALL drop ramREN and ramWEN asynchronously, in the same cycle.
REQ-033 After RST deasserts, the first grant SHALL go to requester 0 if both requesters are active.

Configuration
REQ-034 Macro RAM_TIMEOUT_EN SHALL compile the watchdog in; the counter is 8-bit.
REQ-035 With RAM_TIMEOUT_EN defined:
- the counter clears on entry to OWNED;
- it increments each OWNED cycle without ACCESS;
- on reaching TIMEOUT_CYCLES, the owner's req_err pulses for 1 cycle, next state is IDLE, and the pointer moves to the non-owner.
REQ-036 Without RAM_TIMEOUT_EN, there SHALL be no counter, req_err SHALL be tied to 0, and OWNED waits on the RAM indefinitely.

Verification
REQ-037 Single read: requester 0 reads 0x100, RAM returns ACCESS on the 3rd OWNED cycle with ramload=0xDEADBEEF -> req_wait[0] low exactly that cycle, req_load=0xDEADBEEF, and IDLE on the next cycle.
REQ-038 Contention: both requesters continuously read, RAM has 1-cycle ACCESS -> grant order 0,1,0,1 and each transaction takes 2 cycles.
REQ-039 Write priority: requester 1 raises req_ren=1 and req_wen=1, store 0x12345678, addr 0x40 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
REQ-040 Abort: owner drops its request after 2 OWNED cycles -> IDLE next cycle, strobes 0, pointer unchanged.
REQ-041 Reset mid-op: RST rises during OWNED with ramWEN=1 -> ramWEN=0 the same cycle; after release, requester 0 is granted first.
REQ-042 Timeout (with RAM_TIMEOUT_EN, TIMEOUT_CYCLES=4): ramstate held BUSY -> req_err for the owner pulses after 4 OWNED cycles, then the other requester is granted.
